// File: rtl/div_pkg.sv
// Shared definitions for the divide scheduler.
//   DIV_WIDTH_DEF : default operand/result width
//   DIV_NREQ_DEF  : default number of requesters
//   t_sched_state : scheduler FSM state encoding
package div_pkg;

    localparam int DIV_WIDTH_DEF = 8;
    localparam int DIV_NREQ_DEF  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } t_sched_state;

endpackage

// File: rtl/div_core.sv
// Restoring shift-subtract unsigned divider.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : one-cycle start pulse, operands sampled with it
//   i_dividend     : dividend
//   i_divisor      : divisor (must be nonzero)
//   o_quotient     : quotient, valid when o_done pulses
//   o_remain       : remainder, valid when o_done pulses
//   o_done         : one-cycle pulse WIDTH+2 cycles after start is sampled
module div_core #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remain,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic             done_q;

    // Partial remainder shifted left with the next dividend bit, and the trial
    // subtraction. The extra top bit of diff is the borrow.
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs_q};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (i_start) begin
            quo_q  <= i_dividend;
            rem_q  <= '0;
            dvs_q  <= i_divisor;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            if (cnt_q != CW'(WIDTH)) begin
                // Dividend bits shift out of quo_q while quotient bits shift in.
                if (!diff[WIDTH]) begin
                    rem_q <= diff[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= rem_shift[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_q <= cnt_q + 1'b1;
            end else begin
                // One settle cycle after the last step gives the WIDTH+2 latency.
                done_q <= 1'b1;
                run_q  <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign o_quotient = quo_q;
    assign o_remain   = rem_q;
    assign o_done     = done_q;

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one divider among NREQ requesters.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : per-requester request level, held until granted
//   i_dividend     : packed dividends, requester k at [k*WIDTH +: WIDTH]
//   i_divisor      : packed divisors, same slicing
//   o_gnt          : one-hot grant pulse, operands captured that cycle
//   o_valid        : one-hot result pulse to the owning requester
//   o_quotient     : result quotient, held until next response
//   o_remain       : result remainder, held until next response
//   o_dbz          : divide-by-zero flag for the current result
//   o_busy         : high whenever the scheduler is not idle
module div_sched
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF,
    parameter int NREQ  = DIV_NREQ_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_dividend,
    input  logic [NREQ*WIDTH-1:0] i_divisor,
    output logic [NREQ-1:0]       o_gnt,
    output logic [NREQ-1:0]       o_valid,
    output logic [WIDTH-1:0]      o_quotient,
    output logic [WIDTH-1:0]      o_remain,
    output logic                  o_dbz,
    output logic                  o_busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    t_sched_state     state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [NREQ-1:0]  valid_q, valid_d;
    logic             busy_q;

    logic [NREQ-1:0]  gnt;
    logic             core_start;
    logic [WIDTH-1:0] core_quo;
    logic [WIDTH-1:0] core_rem;
    logic             core_done;

    logic [WIDTH-1:0] dvd_arr [NREQ];
    logic [WIDTH-1:0] dvs_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign dvd_arr[gi] = i_dividend[gi*WIDTH +: WIDTH];
            assign dvs_arr[gi] = i_divisor[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search: scanning offsets from high to low lets the smallest
    // offset from ptr_q win, i.e. the first requester at or after the pointer.
    logic           arb_found;
    logic [IDW-1:0] arb_sel;
    logic [IDW:0]   arb_sum;

    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_sum   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            arb_sum = {1'b0, ptr_q} + (IDW+1)'(i);
            if (arb_sum >= (IDW+1)'(NREQ)) begin
                arb_sum = arb_sum - (IDW+1)'(NREQ);
            end
            if (i_req[arb_sum[IDW-1:0]]) begin
                arb_found = 1'b1;
                arb_sel   = arb_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        valid_d    = '0;
        gnt        = '0;
        core_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by reset so no grant shows while the block is held in reset.
                if (arb_found && i_rst_n) begin
                    gnt[arb_sel] = 1'b1;
                    id_d         = arb_sel;
                    dvd_d        = dvd_arr[arb_sel];
                    dvs_d        = dvs_arr[arb_sel];
                    if (dvs_arr[arb_sel] == '0) begin
                        // Divide by zero is answered without the core.
                        quo_d            = '1;
                        rem_d            = dvd_arr[arb_sel];
                        dbz_d            = 1'b1;
                        valid_d[arb_sel] = 1'b1;
                        state_d          = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                core_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    quo_d         = core_quo;
                    rem_d         = core_rem;
                    dbz_d         = 1'b0;
                    valid_d[id_q] = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            valid_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (core_start),
        .i_dividend (dvd_q),
        .i_divisor  (dvs_q),
        .o_quotient (core_quo),
        .o_remain   (core_rem),
        .o_done     (core_done)
    );

    assign o_gnt      = gnt;
    assign o_valid    = valid_q;
    assign o_quotient = quo_q;
    assign o_remain   = rem_q;
    assign o_dbz      = dbz_q;
    assign o_busy     = busy_q;

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports: i_clk (input, 1, rising-edge clock) and i_rst_n (input, 1, asynchronous active-low reset).
REQ-004 SHALL have i_req  input  NREQ  per-requester request level, held until granted.
REQ-005 SHALL have i_dividend  input  NREQ*WIDTH  packed operands; requester k uses slice [k*WIDTH +: WIDTH].
REQ-006 SHALL have i_divisor  input  NREQ*WIDTH  packed divisors, same slicing as i_dividend.
REQ-007 SHALL have o_gnt  output  NREQ  one-hot, one-cycle pulse; operands of the granted requester are captured in that cycle.
REQ-008 SHALL have o_valid  output  NREQ  one-hot, one-cycle result pulse to the owning requester.
REQ-009 SHALL have o_quotient, o_remain  output  WIDTH each  shared registered results, held until the next response.
REQ-010 SHALL have o_dbz  output  1  registered divide-by-zero flag for the current result.
REQ-011 SHALL have o_busy  output  1  high in every state except S_IDLE.

Function
REQ-012 SHALL implement FSM states S_IDLE, S_ISSUE, S_WAIT and S_RESP.
REQ-013 In S_IDLE with any i_req high: SHALL grant the first requester found at or after r_ptr (round-robin), pulse o_gnt, and capture the operands and requester id.
REQ-014 On grant with captured divisor==0: SHALL go directly to S_RESP with quotient all-ones, remainder=dividend, o_dbz=1, and SHALL NOT start the core.
REQ-015 On grant with nonzero divisor: SHALL go to S_ISSUE, and S_ISSUE SHALL pulse core start for one cycle and then go to S_WAIT.
REQ-016 S_WAIT SHALL hold until core done, then latch the core quotient and remainder (o_dbz=0) and go to S_RESP.
REQ-017 S_RESP SHALL pulse o_valid[id] for one cycle, set r_ptr=(id+1) mod NREQ, and return to S_IDLE.
REQ-018 Latency: grant at cycle t SHALL give o_valid at t+WIDTH+4 for a nonzero divisor and at t+1 for a zero divisor.
REQ-019 No new grant SHALL be issued outside S_IDLE; requests arriving while busy SHALL wait without being lost while still asserted.
REQ-020 A request deasserted before being granted SHALL have no effect.
REQ-021 A continuously asserting requester SHALL NOT be granted twice while another requester is pending (starvation-free).
REQ-022 Division SHALL be unsigned; quotient and remainder SHALL be exact for all nonzero divisors, with remainder < divisor.
REQ-023 o_gnt and o_valid SHALL each have at most one bit high, and SHALL never both be high in the same cycle.

Reset
REQ-024 While i_rst_n is low: SHALL force state=S_IDLE, r_ptr=0, o_quotient=0, o_remain=0, o_dbz=0, o_gnt=0, o_valid=0, o_busy=0; the core is reset by the same signal.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no o_valid pulse; the first grant after release SHALL obey REQ-013 with r_ptr=0.

Structure
REQ-026 The state enum t_sched_state and the default WIDTH/NREQ localparams SHALL live in shared package div_pkg.
REQ-027 The block SHALL instantiate one sub-module div_core: an active-low-reset, restoring shift-subtract unsigned divider that takes a start pulse and asserts done WIDTH+2 cycles after the start is sampled.
REQ-028 All outputs except o_gnt SHALL be driven from registers; o_gnt is a combinational decode of S_IDLE and the arbitration result.

Verification (WIDTH=8, NREQ=4; grant cycle = t0)
REQ-029 Single request: req[0], 200/7 -> o_gnt[0] at t0; o_valid[0] at t12; quotient 28, remain 4, dbz 0.
REQ-030 Divide by zero: req[1], 55/0 -> o_valid[1] at t1; quotient 255, remain 55, dbz 1.
REQ-031 Contention: all four requesting from reset -> grant order 0,1,2,3; each o_valid precedes the next grant; o_busy low only between operations.
REQ-032 Fairness: req[0] held high and req[2] pulsed during op 0 -> next grant goes to 2, not 0.
REQ-033 Reset mid-operation: i_rst_n low during S_WAIT -> no o_valid; all outputs 0; the next request from 3 with 0 also pending -> grant to 0.
REQ-034 Boundary operands: 255/1 -> quotient 255, remain 0; 3/10 -> quotient 0, remain 3; 255/255 -> quotient 1, remain 0.
